// File: rtl/pipeline_pkg.sv
// Shared types for the processor pipeline stage registers.
// Holds the fetch/decode bundle, the NOP encoding and stage states.
package pipeline_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instruction;
    } fetch_decode_t;

    localparam int FETCH_DECODE_W = $bits(fetch_decode_t);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } stage_state_e;

    function automatic logic [1:0] occ_of(stage_state_e s);
        unique case (s)
            EMPTY:   occ_of = 2'd0;
            FULL:    occ_of = 2'd1;
            SKID:    occ_of = 2'd2;
            default: occ_of = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/pipeline_stage_skid.sv
// Generic valid/ready pipeline register with skid buffer and flush.
// Ports:
//   clock, reset     : rising-edge clock, synchronous active-high reset
//   flush            : squash all held entries, output becomes a bubble
//   in_valid/in_ready/in_data    : upstream handshake and payload
//   out_valid/out_ready/out_data : downstream handshake and payload
//   occupancy        : number of held entries (0..2)
module pipeline_stage_skid
    import pipeline_pkg::*;
#(
    parameter int              DATA_W   = 64,
    parameter logic [DATA_W-1:0] NOP_DATA = 64'h0000_0000_0000_0013,
    parameter bit              SKID_EN  = 1'b1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    stage_state_e      state_q, state_d;
    logic [DATA_W-1:0] main_q, main_d;
    logic [DATA_W-1:0] skid_q, skid_d;
    logic              out_valid_q;
    logic [1:0]        occ_q;
    logic              in_ready_q;

    logic in_fire;
    logic out_fire;

    // Without the skid entry, readiness must follow out_ready directly;
    // in_ready_q then only masks the reset cycle.
    assign in_ready = SKID_EN ? in_ready_q
                    : (in_ready_q && (!out_valid_q || out_ready));

    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid_q && out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            // A same-cycle output transfer has already been consumed.
            state_d = EMPTY;
            main_d  = NOP_DATA;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        state_d = FULL;
                        main_d  = in_data;
                    end
                end
                FULL: begin
                    if (in_fire && out_fire) begin
                        main_d = in_data;
                    end else if (out_fire) begin
                        state_d = EMPTY;
                        main_d  = NOP_DATA;
                    end else if (in_fire) begin
                        state_d = SKID;
                        skid_d  = in_data;
                    end
                end
                SKID: begin
                    if (out_fire) begin
                        state_d = FULL;
                        main_d  = skid_q;
                    end
                end
                default: begin
                    state_d = EMPTY;
                    main_d  = NOP_DATA;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= EMPTY;
            main_q      <= NOP_DATA;
            skid_q      <= NOP_DATA;
            out_valid_q <= 1'b0;
            occ_q       <= 2'd0;
            in_ready_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            out_valid_q <= (state_d != EMPTY);
            occ_q       <= occ_of(state_d);
            in_ready_q  <= !SKID_EN || (state_d != SKID);
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = main_q;
    assign occupancy = occ_q;

endmodule

// File: tb/tb_pipeline_stage_skid.sv
// Self-checking bench for pipeline_stage_skid (skid and no-skid builds).
// Table vectors, hand sequences and a queue-based random reference.
module tb_pipeline_stage_skid;

    localparam logic [63:0] NOP = 64'h0000_0000_0000_0013;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [63:0] in_data = '0;

    logic        s_ir, s_ov, z_ir, z_ov;
    logic [63:0] s_od, z_od;
    logic [1:0]  s_occ, z_occ;

    int total = 0;
    int bad = 0;

    always #5 clock = ~clock;

    pipeline_stage_skid #(.DATA_W(64), .NOP_DATA(NOP), .SKID_EN(1'b1)) u_dut (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(s_ir), .in_data(in_data),
        .out_valid(s_ov), .out_ready(out_ready), .out_data(s_od),
        .occupancy(s_occ)
    );

    pipeline_stage_skid #(.DATA_W(64), .NOP_DATA(NOP), .SKID_EN(1'b0)) u_dut0 (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(z_ir), .in_data(in_data),
        .out_valid(z_ov), .out_ready(out_ready), .out_data(z_od),
        .occupancy(z_occ)
    );

    typedef struct {
        bit          iv;
        logic [63:0] d;
        bit          ordy;
        bit          fl;
        bit          e_ov;
        logic [63:0] e_od;
        logic [1:0]  e_occ;
        bit          e_ir;
    } vec_t;

    vec_t vecs[18];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_s(input string nm, input bit ov, input logic [63:0] od,
                         input logic [1:0] oc, input bit ir);
        chk({nm, ".ov"}, {63'd0, s_ov}, {63'd0, ov});
        chk({nm, ".od"}, s_od, od);
        chk({nm, ".occ"}, {62'd0, s_occ}, {62'd0, oc});
        chk({nm, ".ir"}, {63'd0, s_ir}, {63'd0, ir});
    endtask

    function automatic vec_t mk(bit iv, logic [63:0] d, bit ordy, bit fl,
                                bit ov, logic [63:0] od, logic [1:0] oc,
                                bit ir);
        vec_t v;
        v.iv = iv; v.d = d; v.ordy = ordy; v.fl = fl;
        v.e_ov = ov; v.e_od = od; v.e_occ = oc; v.e_ir = ir;
        return v;
    endfunction

    localparam logic [63:0] A0 = 64'h0000_0000_0050_0093;
    localparam logic [63:0] A1 = 64'h0000_0004_0010_0113;
    localparam logic [63:0] A2 = 64'h0000_0008_0020_81B3;
    localparam logic [63:0] B0 = 64'h0000_0010_1111_1111;
    localparam logic [63:0] B1 = 64'h0000_0014_2222_2222;
    localparam logic [63:0] C0 = 64'h0000_0020_3333_3333;
    localparam logic [63:0] D0 = 64'h0000_0030_4444_4444;
    localparam logic [63:0] E0 = 64'h0000_0034_5555_5555;
    localparam logic [63:0] F0 = 64'h0000_0040_6666_6666;
    localparam logic [63:0] G0 = 64'h0000_0044_7777_7777;

    logic [63:0] qs[$];
    logic [63:0] qz[$];

    initial begin
        vecs[0]  = mk(1, A0, 1, 0, 1, A0,  2'd1, 1);
        vecs[1]  = mk(1, A1, 1, 0, 1, A1,  2'd1, 1);
        vecs[2]  = mk(1, A2, 1, 0, 1, A2,  2'd1, 1);
        vecs[3]  = mk(0, '0, 1, 0, 0, NOP, 2'd0, 1);
        vecs[4]  = mk(1, B0, 0, 0, 1, B0,  2'd1, 1);
        vecs[5]  = mk(1, B1, 0, 0, 1, B0,  2'd2, 0);
        vecs[6]  = mk(0, '0, 0, 0, 1, B0,  2'd2, 0);
        vecs[7]  = mk(0, '0, 1, 0, 1, B1,  2'd1, 1);
        vecs[8]  = mk(0, '0, 1, 0, 0, NOP, 2'd0, 1);
        vecs[9]  = mk(1, B0, 0, 0, 1, B0,  2'd1, 1);
        vecs[10] = mk(1, B1, 0, 0, 1, B0,  2'd2, 0);
        vecs[11] = mk(1, C0, 0, 1, 0, NOP, 2'd0, 1);
        vecs[12] = mk(0, '0, 0, 0, 0, NOP, 2'd0, 1);
        vecs[13] = mk(1, D0, 0, 0, 1, D0,  2'd1, 1);
        vecs[14] = mk(0, '0, 1, 1, 0, NOP, 2'd0, 1);
        vecs[15] = mk(1, D0, 0, 0, 1, D0,  2'd1, 1);
        vecs[16] = mk(1, E0, 0, 1, 0, NOP, 2'd0, 1);
        vecs[17] = mk(0, '0, 0, 0, 0, NOP, 2'd0, 1);

        // reset state
        reset = 1'b1;
        step();
        step();
        chk_s("reset", 0, NOP, 2'd0, 0);
        chk("reset0.ir", {63'd0, z_ir}, 64'd0);
        reset = 1'b0;
        step();
        chk_s("idle", 0, NOP, 2'd0, 1);

        // table vectors on the skid build
        for (int i = 0; i < 18; i++) begin
            in_valid  = vecs[i].iv;
            in_data   = vecs[i].d;
            out_ready = vecs[i].ordy;
            flush     = vecs[i].fl;
            step();
            chk_s($sformatf("vec%0d", i), vecs[i].e_ov, vecs[i].e_od,
                  vecs[i].e_occ, vecs[i].e_ir);
        end
        flush = 1'b0;

        // reset in the middle of a stall
        in_valid = 1'b1; in_data = B0; out_ready = 1'b0;
        step();
        in_data = B1;
        step();
        chk_s("prestall", 1, B0, 2'd2, 0);
        in_valid = 1'b0;
        reset = 1'b1;
        step();
        chk_s("rststall", 0, NOP, 2'd0, 0);
        reset = 1'b0;
        step();
        chk_s("rstdone", 0, NOP, 2'd0, 1);

        // no-skid build: combinational ready and simultaneous replace
        in_valid = 1'b1; in_data = F0; out_ready = 1'b0;
        step();
        chk("ns.ov", {63'd0, z_ov}, 64'd1);
        chk("ns.od", z_od, F0);
        chk("ns.stall_ir", {63'd0, z_ir}, 64'd0);
        in_data = G0; out_ready = 1'b1;
        #1;
        chk("ns.go_ir", {63'd0, z_ir}, 64'd1);
        step();
        chk("ns.repl_od", z_od, G0);
        chk("ns.repl_occ", {62'd0, z_occ}, 64'd1);
        in_valid = 1'b0;
        step();
        chk("ns.empty_ov", {63'd0, z_ov}, 64'd0);
        chk("ns.empty_od", z_od, NOP);

        // randomized run against queue models
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        qs.delete();
        qz.delete();
        begin
            bit rflag = 1'b0;
            for (int c = 0; c < 2000; c++) begin
                bit e_sir, e_zir, s_in, s_out, z_in, z_out;
                reset     = ($urandom_range(0, 59) == 0);
                flush     = ($urandom_range(0, 19) == 0);
                in_valid  = $urandom_range(0, 3) != 0;
                out_ready = $urandom_range(0, 2) != 0;
                in_data   = {$urandom, $urandom};
                #1;
                e_sir = !rflag && (qs.size() < 2);
                e_zir = !rflag && ((qz.size() == 0) || out_ready);
                chk("rs.ov", {63'd0, s_ov}, {63'd0, qs.size() > 0});
                chk("rs.od", s_od, (qs.size() > 0) ? qs[0] : NOP);
                chk("rs.occ", {62'd0, s_occ}, 64'(qs.size()));
                chk("rs.ir", {63'd0, s_ir}, {63'd0, e_sir});
                chk("rz.ov", {63'd0, z_ov}, {63'd0, qz.size() > 0});
                chk("rz.od", z_od, (qz.size() > 0) ? qz[0] : NOP);
                chk("rz.occ", {62'd0, z_occ}, 64'(qz.size()));
                chk("rz.ir", {63'd0, z_ir}, {63'd0, e_zir});
                s_in  = in_valid && e_sir;
                s_out = (qs.size() > 0) && out_ready;
                z_in  = in_valid && e_zir;
                z_out = (qz.size() > 0) && out_ready;
                @(posedge clock);
                if (reset) begin
                    qs.delete();
                    qz.delete();
                    rflag = 1'b1;
                end else begin
                    rflag = 1'b0;
                    if (s_out) void'(qs.pop_front());
                    if (z_out) void'(qz.pop_front());
                    if (flush) begin
                        qs.delete();
                        qz.delete();
                    end else begin
                        if (s_in) qs.push_back(in_data);
                        if (z_in) qz.push_back(in_data);
                    end
                end
                #1;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipeline_stage_skid.md
Name: pipeline_stage_skid

Overview:
Generic pipeline register used between any two processor stages, e.g. fetch→decode or decode→execute. It generalises the plain flop-through stage register with four additions: a parametrised payload width, a valid/ready handshake, stall support through a two-entry skid buffer, and synchronous flush with bubble (NOP) insertion. It registers all outputs, including in_ready, so the stall path does not chain combinationally across stages.

Parameters:
DATA_W, 64, payload width in bits (fetch→decode packs {pc[31:0], instruction[31:0]}).
NOP_DATA, 64'h0000_0000_0000_0013, value driven on out_data when no valid entry is held (bubble; low word is addi x0,x0,0).
SKID_EN, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready.

Ports:
clock  input  1  clock, rising edge.
reset  input  1  reset, synchronous, active-high.
flush  input  1  synchronous squash of all held entries (branch/jump redirect).
in_valid  input  1  upstream holds a valid payload.
in_ready  output  1  stage can accept a payload this cycle.
in_data  input  DATA_W  upstream payload.
out_valid  output  1  out_data is a valid payload.
out_ready  input  1  downstream accepts this cycle.
out_data  output  DATA_W  head payload, or NOP_DATA when out_valid=0.
occupancy  output  2  number of held entries (0..2).

Behaviour:
- Transfers: an input transfer happens when in_valid&&in_ready. An output transfer happens when out_valid&&out_ready. Payloads stay in FIFO order and are never dropped or duplicated, except on flush.
- Reset, checked at the clock edge: out_valid=0, out_data=NOP_DATA, occupancy=0, skid entry invalid. in_ready is 0 while reset is high and 1 in the first cycle after.
- State machine (SKID_EN=1), registers main and skid:
  - EMPTY (occ 0), in_ready=1:
    - input transfer → FULL, main<=in_data.
  - FULL (occ 1), in_ready=1:
    - input and output transfer together → FULL, main<=in_data.
    - output transfer only → EMPTY, out_data<=NOP_DATA.
    - input transfer only → SKID, skid<=in_data.
  - SKID (occ 2), in_ready=0:
    - output transfer → FULL, main<=skid.
- in_ready is a flop equal to "next state != SKID". It never depends combinationally on out_ready.
- Latency: one cycle from in_data to out_data when not stalled. Full throughput is one transfer per cycle while out_ready=1.
- out_data and out_valid hold stable while out_valid&&!out_ready. Verification asserts this.
- Flush:
  - Next state is EMPTY, out_valid<=0, out_data<=NOP_DATA.
  - Flush has priority over a same-cycle input transfer: the input is discarded even though in_ready=1. Upstream treats that payload as squashed.
  - A same-cycle output transfer still completes, because downstream has already consumed it.
  - in_ready=1 in the cycle after a flush.
- Reset overrides flush. Reset mid-stall discards both entries.
- SKID_EN=0:
  - Main register only, occupancy is 0 or 1.
  - in_ready = !out_valid || out_ready, combinational.
  - Flush and reset rules are the same as above.
- in_data is ignored when in_valid=0. out_ready is ignored when out_valid=0.

Decomposition:
- Package pipeline_pkg holds:
  - NOP_INSTR (32'h0000_0013).
  - Typedef fetch_decode_t, a packed struct {pc, instruction}, with FETCH_DECODE_W = $bits(fetch_decode_t).
  - Enum stage_state_e {EMPTY, FULL, SKID}.
- No sub-module is needed. Stage-specific thin wrappers instantiate this block with their payload struct.

Test Plan:
- Reset then idle → out_valid=0, out_data=64'h13, in_ready=1, occupancy=0.
- Streaming with out_ready=1, inputs {pc=0x0,inst=0x00500093}, {0x4,0x00100113}, {0x8,0x002081B3} on consecutive cycles → the same three values appear on out_data one cycle later, back-to-back, with in_ready never 0.
- Stall: send A (pc 0x10) and B (pc 0x14) with out_ready=0 → occupancy reaches 2, in_ready=0 the cycle after B, out_data holds A. Raise out_ready → A, then B, with no loss and in_ready back to 1.
- Flush while occupancy=2 with in_valid=1 carrying pc 0x20 → next cycle out_valid=0, out_data=NOP_DATA, occupancy=0; pc 0x20 never appears at the output.
- Flush in the same cycle as an output transfer of pc 0x30 → 0x30 counted as delivered, stage empty afterwards. Reset asserted mid-stall → all outputs return to their reset values next cycle.
- SKID_EN=0: out_ready=0 with one entry held → in_ready=0 in the same cycle. Raise out_ready while in_valid=1 → in_ready=1 in the same cycle and a simultaneous replace occurs.
